// File: rtl/gbe_tx_pkg.sv
// gbe_tx_pkg: shared types and constants for the 100GbE TX framer.
// Contents: framer state enum, lane/beat geometry, and the byte-enable
// helper that turns a count of valid 64-bit words into a 64-bit byte mask.
package gbe_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DROP = 2'd2
    } state_t;

    localparam int LANES      = 8;
    localparam int BEAT_BYTES = 64;

    // n words (0..8) -> n*8 contiguous ones in the LSBs; n >= 8 is a full beat.
    function automatic logic [BEAT_BYTES-1:0] be_of(input logic [3:0] n);
        if (n >= 4'd8) begin
            be_of = '1;
        end else begin
            be_of = (64'd1 << {n[2:0], 3'b000}) - 64'd1;
        end
    endfunction

endpackage

// File: rtl/gbe_tx_lane_packer.sv
// gbe_tx_lane_packer: accumulates 64-bit words into a 512-bit beat, lane 0 in the LSBs.
// Ports: word/word_vld in, clear drops the partial beat; beat is the accumulator
// merged with the word arriving this cycle, pending = words in it, beat_done = 8th word now.
module gbe_tx_lane_packer
    import gbe_tx_pkg::*;
(
    input  logic         user_clk,
    input  logic         axis_reset,
    input  logic         word_vld,
    input  logic [63:0]  word,
    input  logic         clear,
    output logic [511:0] beat,
    output logic [3:0]   pending,
    output logic         beat_done
);

    logic [511:0] acc;
    logic [2:0]   lane;

    // Lanes above the current one are always zero in acc, so the merged view
    // is already zero-filled for partial beats.
    always_comb begin
        beat = acc;
        if (word_vld) begin
            beat[{lane, 6'b000000} +: 64] = word;
        end
    end

    assign pending   = {1'b0, lane} + {3'b000, word_vld};
    assign beat_done = word_vld && (lane == 3'(LANES - 1));

    always_ff @(posedge user_clk or posedge axis_reset) begin
        if (axis_reset) begin
            acc  <= '0;
            lane <= '0;
        end else if (clear || beat_done) begin
            acc  <= '0;
            lane <= '0;
        end else if (word_vld) begin
            acc  <= beat;
            lane <= lane + 3'd1;
        end
    end

endmodule

// File: rtl/gbe_tx_framer.sv
// gbe_tx_framer: packs a 64-bit stream into 512-bit beats and frames fixed-length
// UDP packets for the 100GbE core TX interface; admission decided per packet from afull.
// Ports: en/din/din_valid/din_flush/dest_*_in in; gbe_tx_* out; pkt/drop/overflow counters, busy.
module gbe_tx_framer
    import gbe_tx_pkg::*;
#(
    parameter int PKT_BEATS = 128,
    parameter int CNT_W     = 32
) (
    input  logic             user_clk,
    input  logic             axis_reset,
    input  logic             en,
    input  logic [63:0]      din,
    input  logic             din_valid,
    input  logic             din_flush,
    input  logic [31:0]      dest_ip_in,
    input  logic [15:0]      dest_port_in,
    input  logic             gbe_tx_afull,
    input  logic             gbe_tx_overflow,
    output logic [511:0]     gbe_tx_data,
    output logic [3:0]       gbe_tx_valid,
    output logic [63:0]      gbe_tx_byte_enable,
    output logic             gbe_tx_end_of_frame,
    output logic [31:0]      gbe_tx_dest_ip,
    output logic [15:0]      gbe_tx_dest_port,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count,
    output logic [CNT_W-1:0] overflow_count,
    output logic             busy
);

    localparam logic [9:0]  BEAT_LAST = 10'(PKT_BEATS - 1);
    localparam logic [13:0] DROP_LAST = 14'(PKT_BEATS * LANES - 1);

    state_t state_q, state_d;

    logic [511:0] beat;
    logic [3:0]   pending;
    logic         beat_done;

    logic [9:0]   beat_cnt;
    logic [13:0]  drop_cnt;
    logic [31:0]  dest_ip_lat;
    logic [15:0]  dest_port_lat;

    // Hold-back register. held: a non-final beat waiting for proof that more data
    // follows. tail_pend: the closing partial beat of a flush that also had to
    // release a held beat, so it goes out one cycle later.
    logic [511:0] hold_dat;
    logic [63:0]  hold_be;
    logic         held;
    logic         tail_pend;

    logic         out_vld;

    logic start_ok, start_fill, start_drop, fill_act, word_acc;
    logic final_beat, pkt_end, drop_act, drop_word, drop_end;
    logic emit_vld, emit_eof, hold_load, tail_set;
    logic [511:0] emit_dat;
    logic [63:0]  emit_be, hold_load_be;

    // A new packet waits while a tail beat is still owed, so the tail and a
    // one-word packet can never compete for the same output cycle.
    assign start_ok   = (state_q == IDLE) && en && din_valid && !tail_pend;
    assign start_fill = start_ok && !gbe_tx_afull;
    assign start_drop = start_ok && gbe_tx_afull;
    assign fill_act   = (state_q == FILL) || start_fill;
    assign word_acc   = start_fill || ((state_q == FILL) && din_valid);
    assign final_beat = beat_done && (beat_cnt == BEAT_LAST);
    assign pkt_end    = fill_act && (din_flush || final_beat);
    assign drop_act   = (state_q == DROP) || start_drop;
    assign drop_word  = start_drop || ((state_q == DROP) && din_valid);
    assign drop_end   = drop_act && (din_flush || (drop_word && (drop_cnt == DROP_LAST)));

    gbe_tx_lane_packer u_packer (
        .user_clk   (user_clk),
        .axis_reset (axis_reset),
        .word_vld   (word_acc),
        .word       (din),
        .clear      (pkt_end),
        .beat       (beat),
        .pending    (pending),
        .beat_done  (beat_done)
    );

    always_ff @(posedge user_clk or posedge axis_reset) begin
        if (axis_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_fill && !pkt_end) begin
                    state_d = FILL;
                end else if (start_drop && !drop_end) begin
                    state_d = DROP;
                end
            end
            FILL: if (pkt_end)  state_d = IDLE;
            DROP: if (drop_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output-slot arbitration: at most one beat leaves per cycle.
    always_comb begin
        emit_vld     = 1'b0;
        emit_dat     = hold_dat;
        emit_be      = '1;
        emit_eof     = 1'b0;
        hold_load    = 1'b0;
        hold_load_be = '1;
        tail_set     = 1'b0;
        if (tail_pend) begin
            emit_vld = 1'b1;
            emit_be  = hold_be;
            emit_eof = 1'b1;
        end else if (fill_act) begin
            if (din_flush) begin
                emit_vld = 1'b1;
                if (held) begin
                    if (pending != 4'd0) begin
                        hold_load    = 1'b1;
                        hold_load_be = be_of(pending);
                        tail_set     = 1'b1;
                    end else begin
                        // Nothing pending: the held beat itself closes the packet.
                        emit_eof = 1'b1;
                    end
                end else begin
                    emit_dat = beat;
                    emit_be  = be_of(pending);
                    emit_eof = 1'b1;
                end
            end else if (final_beat) begin
                emit_vld = 1'b1;
                emit_dat = beat;
                emit_eof = 1'b1;
            end else if (beat_done) begin
                hold_load = 1'b1;
            end else if (word_acc && held) begin
                emit_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge user_clk or posedge axis_reset) begin
        if (axis_reset) begin
            beat_cnt            <= '0;
            drop_cnt            <= '0;
            dest_ip_lat         <= '0;
            dest_port_lat       <= '0;
            hold_dat            <= '0;
            hold_be             <= '0;
            held                <= 1'b0;
            tail_pend           <= 1'b0;
            out_vld             <= 1'b0;
            gbe_tx_data         <= '0;
            gbe_tx_byte_enable  <= '0;
            gbe_tx_end_of_frame <= 1'b0;
            gbe_tx_dest_ip      <= '0;
            gbe_tx_dest_port    <= '0;
            pkt_count           <= '0;
            drop_count          <= '0;
            overflow_count      <= '0;
        end else begin
            if (start_fill) begin
                dest_ip_lat   <= dest_ip_in;
                dest_port_lat <= dest_port_in;
            end

            if (pkt_end) begin
                beat_cnt <= '0;
            end else if (beat_done) begin
                beat_cnt <= beat_cnt + 10'd1;
            end

            if (hold_load) begin
                hold_dat <= beat;
                hold_be  <= hold_load_be;
            end
            if (pkt_end) begin
                held <= 1'b0;
            end else if (beat_done) begin
                held <= 1'b1;
            end else if (word_acc && held) begin
                held <= 1'b0;
            end
            tail_pend <= tail_set;

            out_vld <= emit_vld;
            if (emit_vld) begin
                gbe_tx_data         <= emit_dat;
                gbe_tx_byte_enable  <= emit_be;
                gbe_tx_end_of_frame <= emit_eof;
                // A one-word packet leaves before the latch has taken the inputs.
                gbe_tx_dest_ip      <= start_fill ? dest_ip_in   : dest_ip_lat;
                gbe_tx_dest_port    <= start_fill ? dest_port_in : dest_port_lat;
            end

            if (drop_end) begin
                drop_cnt   <= '0;
                drop_count <= drop_count + CNT_W'(1);
            end else if (drop_word) begin
                drop_cnt <= drop_cnt + 14'd1;
            end

            if (pkt_end) begin
                pkt_count <= pkt_count + CNT_W'(1);
            end
            if (gbe_tx_overflow) begin
                overflow_count <= overflow_count + CNT_W'(1);
            end
        end
    end

    assign gbe_tx_valid = {4{out_vld}};
    assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_gbe_tx_framer.sv
// tb_gbe_tx_framer: randomized and directed stimulus for gbe_tx_framer (PKT_BEATS=2),
// checked against a packet-level reference model (word list -> expected beats).
// Ports: none; drives every DUT input, collects every emitted beat at negedge.
module tb_gbe_tx_framer;

    localparam int PB   = 2;
    localparam int FULL = PB * 8;

    logic         user_clk = 1'b0;
    logic         axis_reset;
    logic         en, din_valid, din_flush, gbe_tx_afull, gbe_tx_overflow;
    logic [63:0]  din;
    logic [31:0]  dest_ip_in;
    logic [15:0]  dest_port_in;
    logic [511:0] gbe_tx_data;
    logic [3:0]   gbe_tx_valid;
    logic [63:0]  gbe_tx_byte_enable;
    logic         gbe_tx_end_of_frame;
    logic [31:0]  gbe_tx_dest_ip;
    logic [15:0]  gbe_tx_dest_port;
    logic [31:0]  pkt_count, drop_count, overflow_count;
    logic         busy;

    always #5 user_clk = ~user_clk;

    gbe_tx_framer #(.PKT_BEATS(PB), .CNT_W(32)) dut (
        .user_clk            (user_clk),
        .axis_reset          (axis_reset),
        .en                  (en),
        .din                 (din),
        .din_valid           (din_valid),
        .din_flush           (din_flush),
        .dest_ip_in          (dest_ip_in),
        .dest_port_in        (dest_port_in),
        .gbe_tx_afull        (gbe_tx_afull),
        .gbe_tx_overflow     (gbe_tx_overflow),
        .gbe_tx_data         (gbe_tx_data),
        .gbe_tx_valid        (gbe_tx_valid),
        .gbe_tx_byte_enable  (gbe_tx_byte_enable),
        .gbe_tx_end_of_frame (gbe_tx_end_of_frame),
        .gbe_tx_dest_ip      (gbe_tx_dest_ip),
        .gbe_tx_dest_port    (gbe_tx_dest_port),
        .pkt_count           (pkt_count),
        .drop_count          (drop_count),
        .overflow_count      (overflow_count),
        .busy                (busy)
    );

    typedef struct {
        logic [511:0] dat;
        logic [63:0]  be;
        logic         eof;
        logic [31:0]  ip;
        logic [15:0]  port;
    } beat_t;

    beat_t got_q[$];
    beat_t exp_q[$];
    int checks = 0;
    int errors = 0;
    int pkt_exp = 0;
    int drop_exp = 0;
    int ovf_exp = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Collect every beat the DUT emits.
    always @(negedge user_clk) begin
        if (!axis_reset && gbe_tx_valid != 4'b0000) begin
            beat_t b;
            chk("valid_bits", 512'(gbe_tx_valid), 512'(4'hF));
            b.dat  = gbe_tx_data;
            b.be   = gbe_tx_byte_enable;
            b.eof  = gbe_tx_end_of_frame;
            b.ip   = gbe_tx_dest_ip;
            b.port = gbe_tx_dest_port;
            got_q.push_back(b);
        end
    end

    always @(posedge user_clk) begin
        if (!axis_reset && gbe_tx_overflow) ovf_exp++;
    end

    // One clock of stimulus: inputs applied, then the edge, then 1 time unit.
    task automatic cyc(input bit v, input logic [63:0] d, input bit f, input bit e, input bit a);
        din_valid       = v;
        din             = d;
        din_flush       = f;
        en              = e;
        gbe_tx_afull    = a;
        gbe_tx_overflow = ($urandom_range(0, 3) == 0);
        @(posedge user_clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(0, {$urandom, $urandom}, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Reference: words are cut into groups of 8; each group is one beat whose
    // byte mask covers exactly its words; the last group closes the frame.
    task automatic model_pkt(input logic [63:0] w[$], input logic [31:0] ip, input logic [15:0] port);
        int n;
        int nb;
        n  = w.size();
        nb = (n + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            beat_t e;
            e.dat = '0;
            e.be  = '0;
            for (int k = 0; k < 8; k++) begin
                if (b * 8 + k < n) begin
                    e.dat[64*k +: 64] = w[b*8 + k];
                    e.be[8*k +: 8]    = 8'hFF;
                end
            end
            e.eof  = (b == nb - 1);
            e.ip   = ip;
            e.port = port;
            exp_q.push_back(e);
        end
        pkt_exp++;
    endtask

    task automatic cmp_all();
        beat_t g, e;
        chk("beat_count", 512'(got_q.size()), 512'(exp_q.size()));
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front();
            e = exp_q.pop_front();
            chk("beat_dat", g.dat, e.dat);
            chk("beat_be", 512'(g.be), 512'(e.be));
            chk("beat_eof", 512'(g.eof), 512'(e.eof));
            chk("beat_ip", 512'(g.ip), 512'(e.ip));
            chk("beat_port", 512'(g.port), 512'(e.port));
        end
        got_q.delete();
        exp_q.delete();
        chk("pkt_count", 512'(pkt_count), 512'(pkt_exp));
        chk("drop_count", 512'(drop_count), 512'(drop_exp));
        chk("overflow_count", 512'(overflow_count), 512'(ovf_exp));
        chk("busy_idle", 512'(busy), 512'(0));
    endtask

    task automatic reset_dut();
        axis_reset      = 1'b1;
        gbe_tx_overflow = 1'b0;
        #1;
        chk("rst_valid", 512'(gbe_tx_valid), 512'(0));
        chk("rst_data", gbe_tx_data, 512'(0));
        chk("rst_be", 512'(gbe_tx_byte_enable), 512'(0));
        chk("rst_eof", 512'(gbe_tx_end_of_frame), 512'(0));
        chk("rst_dest", 512'({gbe_tx_dest_ip, gbe_tx_dest_port}), 512'(0));
        chk("rst_counts", 512'({pkt_count, drop_count, overflow_count}), 512'(0));
        chk("rst_busy", 512'(busy), 512'(0));
        got_q.delete();
        exp_q.delete();
        pkt_exp  = 0;
        drop_exp = 0;
        ovf_exp  = 0;
        @(posedge user_clk);
        @(posedge user_clk);
        #1;
        axis_reset = 1'b0;
    endtask

    // One packet of n words; en/afull/dest wiggle after the first word and must be ignored.
    task automatic send_pkt(input int n, input bit seq, input logic [63:0] base,
                            input bit fl_last, input bit afull0, input int gap_max);
        logic [63:0] w[$];
        logic [31:0] ip;
        logic [15:0] port;
        bit          fl;
        ip   = $urandom;
        port = 16'($urandom);
        for (int i = 0; i < n; i++) w.push_back(seq ? base + 64'(i) : {$urandom, $urandom});
        dest_ip_in   = ip;
        dest_port_in = port;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, gap_max)) cyc(0, {$urandom, $urandom}, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            fl = fl_last && (n < FULL) && (i == n - 1);
            cyc(1, w[i], fl, (i == 0) ? 1'b1 : 1'($urandom_range(0, 1)),
                (i == 0) ? afull0 : 1'($urandom_range(0, 1)));
            if (i == 0) begin
                dest_ip_in   = $urandom;
                dest_port_in = 16'($urandom);
                if (!(n == 1 && fl)) chk("busy_mid", 512'(busy), 512'(1));
            end
        end
        if (n < FULL && !fl_last) begin
            repeat ($urandom_range(0, gap_max)) cyc(0, 64'd0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            cyc(0, 64'd0, 1, 0, 0);
        end
        cyc(0, 64'd0, 0, 0, 0);
        idle(3);
        if (afull0) drop_exp++;
        else model_pkt(w, ip, port);
    endtask

    initial begin
        logic [63:0] w8[$];
        logic [31:0] ip;
        logic [15:0] port;
        int          n_before;
        en = 0; din = '0; din_valid = 0; din_flush = 0;
        dest_ip_in = '0; dest_port_in = '0; gbe_tx_afull = 0; gbe_tx_overflow = 0;
        reset_dut();

        // Two full beats of words 0..15.
        send_pkt(16, 1, 64'd0, 0, 0, 0);
        cmp_all();
        // 11 words then flush: full beat, then 3-word beat.
        send_pkt(11, 1, 64'd100, 0, 0, 0);
        cmp_all();
        // One-word packet (start and flush together).
        send_pkt(1, 1, 64'd55, 1, 0, 0);
        cmp_all();

        // 8 words, long idle, flush: the held beat must wait for the flush.
        ip = $urandom; port = 16'($urandom);
        dest_ip_in = ip; dest_port_in = port;
        w8.delete();
        for (int i = 0; i < 8; i++) begin
            w8.push_back(64'(200 + i));
            cyc(1, 64'(200 + i), 0, 1, 0);
        end
        idle(5);
        n_before = got_q.size();
        chk("held_no_early", 512'(n_before), 512'(0));
        cyc(0, 64'd0, 1, 0, 0);
        idle(4);
        model_pkt(w8, ip, port);
        cmp_all();

        // Refused packet dropped whole, then a normal one.
        send_pkt(16, 1, 64'd300, 0, 1, 0);
        cmp_all();
        send_pkt(16, 1, 64'd400, 0, 0, 1);
        cmp_all();

        // Ignored in IDLE: valid without en, flush alone.
        cyc(1, 64'd1, 0, 0, 0);
        cyc(1, 64'd2, 0, 0, 1);
        cyc(0, 64'd0, 1, 1, 0);
        idle(3);
        cmp_all();

        // Reset mid-packet, then a clean packet from lane 0.
        for (int i = 0; i < 5; i++) cyc(1, 64'(900 + i), 0, 1, 0);
        reset_dut();
        send_pkt(16, 1, 64'd1000, 0, 0, 0);
        cmp_all();

        // Randomized packets.
        for (int p = 0; p < 40; p++) begin
            send_pkt($urandom_range(1, FULL), 0, 64'd0, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 3) == 0), 2);
            cmp_all();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
